siganfu_fire_controller: RTL

Fire-control unit that drives the command side of siganfu_machine_gun: it generates is_enemy, target_locked, fire_command and firing_mode, and consumes fire_trigger, current_state and criticality_alert.
- Qualifies a radar track and an IFF result into a lock.
- Runs an operator-requested engagement of N rounds, counting fire_trigger pulses.
- Pauses through reload/overheat and aborts on lock loss, criticality or timeout.

---
 rtl/siganfu_pkg.sv | 33 +++
 rtl/siganfu_lock_qualifier.sv | 34 +++
 rtl/siganfu_fire_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/siganfu_pkg.sv
// Shared codes and defaults for the siganfu fire controller and the gun it commands.
package siganfu_pkg;

  typedef enum logic [2:0] {
    GS_IDLE     = 3'd0,
    GS_LOCK     = 3'd1,
    GS_SINGLE   = 3'd2,
    GS_AUTO     = 3'd3,
    GS_RELOAD   = 3'd4,
    GS_OVERHEAT = 3'd5,
    GS_DOWN     = 3'd6
  } gun_state_e;

  typedef enum logic [2:0] {
    FC_IDLE    = 3'd0,
    FC_ACQUIRE = 3'd1,
    FC_LOCKED  = 3'd2,
    FC_ENGAGE  = 3'd3,
    FC_HOLD    = 3'd4,
    FC_DONE    = 3'd5,
    FC_ABORT   = 3'd6
  } fc_state_e;

  localparam int DEF_RND_W        = 5;
  localparam int DEF_LOCK_CYCLES  = 3;
  localparam int DEF_HOLD_TIMEOUT = 20;

  // Gun states during which firing must pause rather than abort.
  function automatic logic gun_paused(input logic [2:0] gs);
    return (gs == GS_RELOAD) || (gs == GS_OVERHEAT);
  endfunction

endpackage

// File: rtl/siganfu_lock_qualifier.sv
// Counts consecutive cycles of a hostile track; lock_ok flags the edge on which
// the run length reaches LOCK_CYCLES.
module siganfu_lock_qualifier
  import siganfu_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic sysclk,
  input  logic reboot,
  input  logic track_valid,
  input  logic iff_hostile,
  input  logic enable,
  output logic lock_ok
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);

  logic [CW-1:0] lock_cnt;
  logic          qual;

  assign qual    = track_valid && iff_hostile;
  assign lock_ok = enable && qual && (lock_cnt == CW'(LOCK_CYCLES - 1));

  always_ff @(posedge sysclk) begin
    if (reboot) begin
      lock_cnt <= '0;
    end else if (!enable || !qual) begin
      lock_cnt <= '0;
    end else if (lock_cnt != CW'(LOCK_CYCLES)) begin
      lock_cnt <= lock_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/siganfu_fire_controller.sv
// Fire-control FSM: qualifies a hostile lock, runs an N-round engagement against
// the gun's trigger feedback, pauses through reload/overheat and aborts on faults.
module siganfu_fire_controller
  import siganfu_pkg::*;
#(
  parameter int RND_W        = DEF_RND_W,
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic             sysclk,
  input  logic             reboot,
  input  logic             track_valid,
  input  logic             iff_hostile,
  input  logic             engage_req,
  input  logic [RND_W-1:0] rounds_req,
  input  logic             fire_trigger,
  input  logic [2:0]       gun_state,
  input  logic             criticality_alert,
  output logic             is_enemy,
  output logic             target_locked,
  output logic             fire_command,
  output logic             firing_mode,
  output logic [RND_W-1:0] rounds_fired,
  output logic             engage_busy,
  output logic             engage_done,
  output logic             engage_abort,
  output logic [2:0]       ctrl_state
);

  localparam int HW = $clog2(HOLD_TIMEOUT + 1);

  fc_state_e        state;
  logic [RND_W-1:0] req_q;
  logic [RND_W-1:0] count_inc;
  logic [HW-1:0]    hold_cnt;
  logic [1:0]       reissue_cnt;
  logic             qual;
  logic             paused;
  logic             lock_ok;
  logic             acquiring;

  assign qual       = track_valid && iff_hostile;
  assign paused     = gun_paused(gun_state);
  assign acquiring  = (state == FC_IDLE) || (state == FC_ACQUIRE);
  assign count_inc  = (rounds_fired == '1) ? rounds_fired : rounds_fired + RND_W'(1);
  assign ctrl_state = state;

  siganfu_lock_qualifier #(
    .LOCK_CYCLES(LOCK_CYCLES)
  ) u_lock (
    .sysclk      (sysclk),
    .reboot      (reboot),
    .track_valid (track_valid),
    .iff_hostile (iff_hostile),
    .enable      (acquiring),
    .lock_ok     (lock_ok)
  );

  always_ff @(posedge sysclk) begin
    if (reboot) begin
      state         <= FC_IDLE;
      is_enemy      <= 1'b0;
      target_locked <= 1'b0;
      fire_command  <= 1'b0;
      firing_mode   <= 1'b0;
      rounds_fired  <= '0;
      engage_busy   <= 1'b0;
      engage_done   <= 1'b0;
      engage_abort  <= 1'b0;
      req_q         <= '0;
      hold_cnt      <= '0;
      reissue_cnt   <= '0;
    end else begin
      engage_done  <= 1'b0;
      engage_abort <= 1'b0;
      is_enemy     <= iff_hostile;
      case (state)
        FC_IDLE: begin
          if (lock_ok) begin
            state         <= FC_LOCKED;
            target_locked <= 1'b1;
          end else if (qual) begin
            state <= FC_ACQUIRE;
          end
        end
        FC_ACQUIRE: begin
          if (!qual) begin
            state <= FC_IDLE;
          end else if (lock_ok) begin
            state         <= FC_LOCKED;
            target_locked <= 1'b1;
          end
        end
        FC_LOCKED: begin
          if (!qual) begin
            state         <= FC_IDLE;
            target_locked <= 1'b0;
          end else if (engage_req && (rounds_req != '0)) begin
            state        <= FC_ENGAGE;
            req_q        <= rounds_req;
            rounds_fired <= '0;
            firing_mode  <= (rounds_req > RND_W'(1));
            fire_command <= 1'b1;
            engage_busy  <= 1'b1;
            reissue_cnt  <= '0;
          end
        end
        FC_ENGAGE: begin
          if (fire_trigger) rounds_fired <= count_inc;
          // Completion is checked first so a final round beats a same-cycle abort.
          if (fire_trigger && (count_inc == req_q)) begin
            state        <= FC_DONE;
            fire_command <= 1'b0;
            engage_busy  <= 1'b0;
            engage_done  <= 1'b1;
          end else if (criticality_alert || !qual) begin
            state         <= FC_ABORT;
            fire_command  <= 1'b0;
            target_locked <= 1'b0;
            is_enemy      <= 1'b0;
            engage_busy   <= 1'b0;
            engage_abort  <= 1'b1;
          end else if (paused) begin
            state        <= FC_HOLD;
            fire_command <= 1'b0;
            hold_cnt     <= HW'(1);
          end else if (firing_mode) begin
            fire_command <= 1'b1;
          end else if (fire_trigger) begin
            fire_command <= 1'b0;
            reissue_cnt  <= 2'd2;
          end else if (reissue_cnt == 2'd1) begin
            fire_command <= 1'b1;
            reissue_cnt  <= '0;
          end else begin
            fire_command <= 1'b0;
            if (reissue_cnt != '0) reissue_cnt <= reissue_cnt - 2'd1;
          end
        end
        FC_HOLD: begin
          if (criticality_alert || !qual || (paused && (hold_cnt == HW'(HOLD_TIMEOUT)))) begin
            state         <= FC_ABORT;
            fire_command  <= 1'b0;
            target_locked <= 1'b0;
            is_enemy      <= 1'b0;
            engage_busy   <= 1'b0;
            engage_abort  <= 1'b1;
          end else if (paused) begin
            hold_cnt <= hold_cnt + HW'(1);
          end else begin
            state        <= FC_ENGAGE;
            fire_command <= 1'b1;
            reissue_cnt  <= '0;
          end
        end
        FC_DONE: begin
          if (qual) begin
            state <= FC_LOCKED;
          end else begin
            state         <= FC_IDLE;
            target_locked <= 1'b0;
          end
        end
        FC_ABORT: begin
          if (criticality_alert) begin
            is_enemy <= 1'b0;
          end else begin
            state <= FC_IDLE;
          end
        end
        default: begin
          state <= FC_IDLE;
        end
      endcase
    end
  end

endmodule
